fl_ckpt_ctrl: RTL and testbench

FL_CKPT_CTRL -- requirements
Module: fl_ckpt_ctrl

---
 rtl/fl_ckpt_ctrl_pkg.sv | 26 ++
 rtl/fl_ckpt_ctrl_stack.sv | 79 +++++++
 rtl/fl_ckpt_ctrl.sv | 164 ++++++++++++++++
 tb/tb_fl_ckpt_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fl_ckpt_ctrl_pkg.sv
// rtl/fl_ckpt_ctrl_pkg.sv - shared processor types for free-list checkpoint control
//
// Purpose: branch-resolution encodings, free-list head width and the FSM
//          state enum used by fl_ckpt_ctrl and fl_ckpt_stack.
// Contents: BR_STATE_W, BR_NONE, BR_PR_CORRECT, BR_PR_WRONG, FL_HEAD_W,
//           ckpt_state_e, head_inc().
package fl_ckpt_ctrl_pkg;

    localparam int BR_STATE_W = 2;
    localparam logic [BR_STATE_W-1:0] BR_NONE       = 2'd0;
    localparam logic [BR_STATE_W-1:0] BR_PR_CORRECT = 2'd1;
    localparam logic [BR_STATE_W-1:0] BR_PR_WRONG   = 2'd2;

    localparam int FL_HEAD_W = 5;

    typedef enum logic {
        ST_NORMAL  = 1'b0,
        ST_RECOVER = 1'b1
    } ckpt_state_e;

    // Free-list head advances modulo 2**FL_HEAD_W; natural wrap of the vector.
    function automatic logic [FL_HEAD_W-1:0] head_inc(input logic [FL_HEAD_W-1:0] h);
        return h + FL_HEAD_W'(1);
    endfunction

endpackage

// File: rtl/fl_ckpt_ctrl_stack.sv
// rtl/fl_ckpt_ctrl_stack.sv - circular checkpoint storage with alloc/free pointers
//
// Purpose: holds one saved free-list head per in-flight branch. Slots are
//          allocated in order at alloc_ptr and freed in order at free_ptr.
//          A restore rewinds alloc_ptr to just past the mispredicted branch
//          and recomputes the occupancy from the surviving range.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   push_i/push_head_i  store push_head_i at alloc_ptr, advance alloc_ptr
//   pop_i             free the oldest slot (ignored when empty)
//   restore_i/restore_tag_i  rewind after a mispredict of restore_tag_i
//   rd_tag_i/rd_head_o  combinational read of one slot
//   alloc_ptr_o       next slot to be allocated
//   full_o            all slots occupied
module fl_ckpt_stack
    import fl_ckpt_ctrl_pkg::*;
#(
    parameter int CKPT_DEPTH = 4,
    localparam int PTR_W = $clog2(CKPT_DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_i,
    input  logic [FL_HEAD_W-1:0] push_head_i,
    input  logic                 pop_i,
    input  logic                 restore_i,
    input  logic [PTR_W-1:0]     restore_tag_i,
    input  logic [PTR_W-1:0]     rd_tag_i,
    output logic [FL_HEAD_W-1:0] rd_head_o,
    output logic [PTR_W-1:0]     alloc_ptr_o,
    output logic                 full_o
);

    logic [FL_HEAD_W-1:0] r_slots [CKPT_DEPTH];
    logic [PTR_W-1:0]     r_alloc_ptr;
    logic [PTR_W-1:0]     r_free_ptr;
    logic [CNT_W-1:0]     r_count;

    logic                 w_pop;
    logic [PTR_W-1:0]     w_restore_dist;

    assign w_pop          = pop_i && (r_count != '0);
    // The mispredicted branch's own slot survives, so the occupied range is
    // free_ptr..restore_tag inclusive; pointer width wraps modulo the depth.
    assign w_restore_dist = restore_tag_i - r_free_ptr;

    assign rd_head_o   = r_slots[rd_tag_i];
    assign alloc_ptr_o = r_alloc_ptr;
    assign full_o      = (r_count == CNT_W'(CKPT_DEPTH));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_alloc_ptr <= '0;
            r_free_ptr  <= '0;
            r_count     <= '0;
            for (int i = 0; i < CKPT_DEPTH; i++) begin
                r_slots[i] <= '0;
            end
        end else if (restore_i) begin
            r_alloc_ptr <= restore_tag_i + PTR_W'(1);
            r_count     <= {1'b0, w_restore_dist} + CNT_W'(1);
        end else begin
            if (push_i) begin
                r_slots[r_alloc_ptr] <= push_head_i;
                r_alloc_ptr          <= r_alloc_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_free_ptr <= r_free_ptr + PTR_W'(1);
            end
            case ({push_i, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fl_ckpt_ctrl.sv
// rtl/fl_ckpt_ctrl.sv - dispatch grant and branch checkpoint/recovery for the free list
//
// Purpose: grants physical-register requests from the decoder, tracks a
//          shadow copy of the free-list head, checkpoints it for every
//          granted branch and, on a mispredict, issues a one-cycle recovery
//          command that restores the free-list head.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   dispatch_req_i, is_branch_i  decoder request / request is a branch
//   dispatch_gnt_o, br_tag_o     grant (combinational) and branch slot
//   fl_free_preg_vld_i       free list not empty
//   fl_dispatch_en_o         pop strobe to the free list
//   br_state_i, br_tag_i     branch resolution from the ROB
//   fl_branch_state_o, fl_rc_head_o  recovery command to the free list
//   ckpt_full_o              all checkpoint slots in use
//   stall_cnt_o, recover_cnt_o   statistics, only with FL_CKPT_STATS_EN
// Build option: define FL_CKPT_STATS_EN to add the statistics counters.
module fl_ckpt_ctrl
    import fl_ckpt_ctrl_pkg::*;
#(
    parameter int CKPT_DEPTH = 4,
    localparam int TAG_W = $clog2(CKPT_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dispatch_req_i,
    input  logic                  is_branch_i,
    output logic                  dispatch_gnt_o,
    output logic [TAG_W-1:0]      br_tag_o,
    input  logic                  fl_free_preg_vld_i,
    output logic                  fl_dispatch_en_o,
    input  logic [BR_STATE_W-1:0] br_state_i,
    input  logic [TAG_W-1:0]      br_tag_i,
    output logic [BR_STATE_W-1:0] fl_branch_state_o,
    output logic [FL_HEAD_W-1:0]  fl_rc_head_o,
    output logic                  ckpt_full_o
`ifdef FL_CKPT_STATS_EN
    ,
    output logic [15:0]           stall_cnt_o,
    output logic [7:0]            recover_cnt_o
`endif
);

    ckpt_state_e           r_state;
    logic [BR_STATE_W-1:0] r_fl_branch_state;
    logic [FL_HEAD_W-1:0]  r_rc_head;
    logic [TAG_W-1:0]      r_rc_tag;
    logic [FL_HEAD_W-1:0]  r_head;

    logic                  w_normal;
    logic                  w_wrong;
    logic                  w_correct;
    logic                  w_enter_rec;
    logic                  w_gnt;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_restore;
    logic                  w_full;
    logic [TAG_W-1:0]      w_alloc_ptr;
    logic [FL_HEAD_W-1:0]  w_ckpt_head;

    assign w_normal    = (r_state == ST_NORMAL);
    assign w_wrong     = (br_state_i == BR_PR_WRONG);
    assign w_correct   = (br_state_i == BR_PR_CORRECT);
    assign w_enter_rec = rst && w_normal && w_wrong;
    assign w_restore   = !w_normal;

    // A mispredict blocks dispatch in its own cycle; the full check uses the
    // registered occupancy so a same-cycle correct cannot admit a branch.
    assign w_gnt = rst && w_normal && !w_wrong && dispatch_req_i
                && fl_free_preg_vld_i && (!is_branch_i || !w_full);

    assign w_push = w_gnt && is_branch_i;
    assign w_pop  = w_normal && w_correct;

    assign dispatch_gnt_o    = w_gnt;
    assign fl_dispatch_en_o  = w_gnt;
    assign br_tag_o          = w_alloc_ptr;
    assign fl_branch_state_o = r_fl_branch_state;
    assign fl_rc_head_o      = r_rc_head;
    assign ckpt_full_o       = w_full;

    fl_ckpt_stack #(
        .CKPT_DEPTH (CKPT_DEPTH)
    ) u_stack (
        .clk           (clk),
        .rst           (rst),
        .push_i        (w_push),
        .push_head_i   (head_inc(r_head)),
        .pop_i         (w_pop),
        .restore_i     (w_restore),
        .restore_tag_i (r_rc_tag),
        .rd_tag_i      (br_tag_i),
        .rd_head_o     (w_ckpt_head),
        .alloc_ptr_o   (w_alloc_ptr),
        .full_o        (w_full)
    );

    // Shadow of the free-list head: follows every pop, rewinds on recovery.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head <= '0;
        end else if (w_restore) begin
            r_head <= r_rc_head;
        end else if (w_gnt) begin
            r_head <= head_inc(r_head);
        end
    end

    // Recovery FSM. The command outputs are registered so they are valid for
    // exactly the single RECOVER cycle; reset clears them before they issue.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state           <= ST_NORMAL;
            r_fl_branch_state <= BR_NONE;
            r_rc_head         <= '0;
            r_rc_tag          <= '0;
        end else begin
            case (r_state)
                ST_NORMAL: begin
                    if (w_wrong) begin
                        r_state           <= ST_RECOVER;
                        r_fl_branch_state <= BR_PR_WRONG;
                        r_rc_head         <= w_ckpt_head;
                        r_rc_tag          <= br_tag_i;
                    end
                end
                ST_RECOVER: begin
                    r_state           <= ST_NORMAL;
                    r_fl_branch_state <= BR_NONE;
                    r_rc_head         <= '0;
                end
                default: begin
                    r_state           <= ST_NORMAL;
                    r_fl_branch_state <= BR_NONE;
                    r_rc_head         <= '0;
                end
            endcase
        end
    end

`ifdef FL_CKPT_STATS_EN
    logic [15:0] r_stall_cnt;
    logic [7:0]  r_recover_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt   <= '0;
            r_recover_cnt <= '0;
        end else begin
            if (dispatch_req_i && !w_gnt && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_enter_rec && (r_recover_cnt != 8'hFF)) begin
                r_recover_cnt <= r_recover_cnt + 8'd1;
            end
        end
    end

    assign stall_cnt_o   = r_stall_cnt;
    assign recover_cnt_o = r_recover_cnt;
`endif

endmodule

// File: tb/tb_fl_ckpt_ctrl.sv
// tb/tb_fl_ckpt_ctrl.sv - self-checking bench for fl_ckpt_ctrl with a queue-based model
module tb_fl_ckpt_ctrl;
    import fl_ckpt_ctrl_pkg::*;

    localparam int D     = 4;
    localparam int TAG_W = 2;

    logic                  clk;
    logic                  rst;
    logic                  dispatch_req_i;
    logic                  is_branch_i;
    logic                  dispatch_gnt_o;
    logic [TAG_W-1:0]      br_tag_o;
    logic                  fl_free_preg_vld_i;
    logic                  fl_dispatch_en_o;
    logic [BR_STATE_W-1:0] br_state_i;
    logic [TAG_W-1:0]      br_tag_i;
    logic [BR_STATE_W-1:0] fl_branch_state_o;
    logic [FL_HEAD_W-1:0]  fl_rc_head_o;
    logic                  ckpt_full_o;
`ifdef FL_CKPT_STATS_EN
    logic [15:0]           stall_cnt_o;
    logic [7:0]            recover_cnt_o;
`endif

    fl_ckpt_ctrl #(.CKPT_DEPTH(D)) dut (
        .clk                (clk),
        .rst                (rst),
        .dispatch_req_i     (dispatch_req_i),
        .is_branch_i        (is_branch_i),
        .dispatch_gnt_o     (dispatch_gnt_o),
        .br_tag_o           (br_tag_o),
        .fl_free_preg_vld_i (fl_free_preg_vld_i),
        .fl_dispatch_en_o   (fl_dispatch_en_o),
        .br_state_i         (br_state_i),
        .br_tag_i           (br_tag_i),
        .fl_branch_state_o  (fl_branch_state_o),
        .fl_rc_head_o       (fl_rc_head_o),
        .ckpt_full_o        (ckpt_full_o)
`ifdef FL_CKPT_STATS_EN
        ,
        .stall_cnt_o        (stall_cnt_o),
        .recover_cnt_o      (recover_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int tag;
        int head;
    } ck_t;

    // Model: list of live checkpoints oldest-first, plus the shadow head.
    ck_t q[$];
    int  m_head;
    int  m_alloc;
    bit  m_rec;
    int  m_rc_head;
    int  m_rc_tag;

    int n_checks;
    int n_fail;

    int s_gnt, s_tag, s_bs, s_rc, s_full;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit rq, input bit br, input bit vl,
                        input logic [1:0] bs, input int tg);
        int  exp_gnt;
        int  k;
        @(negedge clk);
        rst                = r;
        dispatch_req_i     = rq;
        is_branch_i        = br;
        fl_free_preg_vld_i = vl;
        br_state_i         = bs;
        br_tag_i           = TAG_W'(tg);
        #2;
        exp_gnt = (r && !m_rec && bs != BR_PR_WRONG && rq && vl
                   && (!br || q.size() < D)) ? 1 : 0;
        s_gnt  = int'(dispatch_gnt_o);
        s_tag  = int'(br_tag_o);
        s_bs   = int'(fl_branch_state_o);
        s_rc   = int'(fl_rc_head_o);
        s_full = int'(ckpt_full_o);
        chk("gnt", s_gnt, exp_gnt);
        chk("dispatch_en", int'(fl_dispatch_en_o), exp_gnt);
        chk("br_tag", s_tag, m_alloc);
        chk("fl_branch_state", s_bs, m_rec ? int'(BR_PR_WRONG) : int'(BR_NONE));
        chk("fl_rc_head", s_rc, m_rec ? m_rc_head : 0);
        chk("ckpt_full", s_full, (q.size() == D) ? 1 : 0);
        @(posedge clk);
        if (!r) begin
            q.delete();
            m_head = 0; m_alloc = 0; m_rec = 0; m_rc_head = 0; m_rc_tag = 0;
        end else if (m_rec) begin
            k = -1;
            foreach (q[i]) if (q[i].tag == m_rc_tag) k = i;
            if (k >= 0) while (q.size() > k + 1) void'(q.pop_back());
            m_head  = m_rc_head;
            m_alloc = (m_rc_tag + 1) % D;
            m_rec   = 0;
        end else if (bs == BR_PR_WRONG) begin
            m_rec     = 1;
            m_rc_tag  = tg;
            m_rc_head = 0;
            foreach (q[i]) if (q[i].tag == tg) m_rc_head = q[i].head;
        end else begin
            if (bs == BR_PR_CORRECT && q.size() > 0) void'(q.pop_front());
            if (exp_gnt == 1) begin
                m_head = (m_head + 1) % 32;
                if (br) begin
                    q.push_back('{tag: m_alloc, head: m_head});
                    m_alloc = (m_alloc + 1) % D;
                end
            end
        end
    endtask

    initial begin
        int t;
        int rq, br, vl, tg;
        logic [1:0] bs;
        n_checks = 0; n_fail = 0;
        q.delete();
        m_head = 0; m_alloc = 0; m_rec = 0; m_rc_head = 0; m_rc_tag = 0;
        rst = 1'b0; dispatch_req_i = 1'b0; is_branch_i = 1'b0;
        fl_free_preg_vld_i = 1'b1; br_state_i = BR_NONE; br_tag_i = '0;
        @(posedge clk);
        @(posedge clk);

        // Reset state.
        step(0, 0, 0, 1, BR_NONE, 0);
        chk("reset_gnt_lit", s_gnt, 0);
        chk("reset_bs_lit", s_bs, 0);

        // Three plain grants: head 0 -> 3.
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 1, BR_NONE, 0);
            chk("plain_gnt_lit", s_gnt, 1);
        end
        chk("model_head3_lit", m_head, 3);

        // Branch at head 3 gets slot 0 holding 4.
        step(1, 1, 1, 1, BR_NONE, 0);
        chk("br_tag0_lit", s_tag, 0);
        chk("model_ckpt0_lit", q[0].head, 4);
        step(1, 1, 0, 1, BR_NONE, 0);
        step(1, 1, 0, 1, BR_NONE, 0);

        // Mispredict tag 0 with a coincident request.
        step(1, 1, 0, 1, BR_PR_WRONG, 0);
        chk("wrong_blocks_gnt_lit", s_gnt, 0);
        step(1, 1, 0, 1, BR_NONE, 0);
        chk("recover_bs_lit", s_bs, 2);
        chk("recover_head_lit", s_rc, 4);
        chk("recover_gnt_lit", s_gnt, 0);

        // Resumed at head 4: next branch saves 5 in slot 1.
        step(1, 1, 1, 1, BR_NONE, 0);
        chk("resume_tag1_lit", s_tag, 1);
        step(1, 0, 0, 1, BR_PR_WRONG, 1);
        step(1, 0, 0, 1, BR_NONE, 0);
        chk("resume_head5_lit", s_rc, 5);

        // Drain, then fill all four slots (tags 2,3,0,1).
        step(1, 0, 0, 1, BR_PR_CORRECT, 0);
        step(1, 0, 0, 1, BR_PR_CORRECT, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 1, 1, BR_NONE, 0);
            if (i == 2) chk("alloc_wrap_lit", s_tag, 0);
        end
        step(1, 1, 1, 1, BR_NONE, 0);
        chk("full_lit", s_full, 1);
        chk("full_br_gnt_lit", s_gnt, 0);
        step(1, 1, 0, 1, BR_NONE, 0);
        chk("full_plain_gnt_lit", s_gnt, 1);
        step(1, 1, 1, 1, BR_PR_CORRECT, 0);
        chk("same_cycle_correct_lit", s_gnt, 0);
        step(1, 1, 1, 1, BR_NONE, 0);
        chk("after_correct_gnt_lit", s_gnt, 1);
        chk("after_correct_tag_lit", s_tag, 2);

        // No free registers.
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, BR_NONE, 0);
            chk("novld_gnt_lit", s_gnt, 0);
        end

        // Head wrap 31 -> 0 observed through a checkpoint.
        while (q.size() > 0) step(1, 0, 0, 1, BR_PR_CORRECT, 0);
        while (m_head != 31) step(1, 1, 0, 1, BR_NONE, 0);
        t = m_alloc;
        step(1, 1, 1, 1, BR_NONE, 0);
        chk("model_wrap_head_lit", m_head, 0);
        step(1, 0, 0, 1, BR_PR_WRONG, t);
        step(1, 0, 0, 1, BR_NONE, 0);
        chk("wrap_bs_lit", s_bs, 2);
        chk("wrap_rc_lit", s_rc, 0);

        // Reset during RECOVER.
        step(1, 1, 1, 1, BR_NONE, 0);
        step(1, 0, 0, 1, BR_PR_WRONG, t);
        step(0, 1, 0, 1, BR_NONE, 0);
        step(1, 0, 0, 1, BR_NONE, 0);
        chk("rst_rec_bs_lit", s_bs, 0);
        chk("rst_rec_tag_lit", s_tag, 0);
        chk("rst_rec_full_lit", s_full, 0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rq = ($urandom_range(0, 9) < 7) ? 1 : 0;
            br = ($urandom_range(0, 9) < 4) ? 1 : 0;
            vl = ($urandom_range(0, 19) < 17) ? 1 : 0;
            bs = BR_NONE;
            tg = 0;
            t  = $urandom_range(0, 99);
            if (m_rec) begin
                bs = 2'($urandom_range(0, 2));
                tg = $urandom_range(0, D - 1);
            end else if (q.size() > 0) begin
                if (t < 8) begin
                    bs = BR_PR_WRONG;
                    tg = q[$urandom_range(0, q.size() - 1)].tag;
                end else if (t < 30) begin
                    bs = BR_PR_CORRECT;
                end
            end else if (t < 10) begin
                bs = BR_PR_CORRECT;
            end
            step(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1,
                 rq[0], br[0], vl[0], bs, tg);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
